// File: rtl/tff_bank_if.sv
// Control/status bundle of the tff_bank flip-flop bank.
// The parity_o signal is present only when TFF_BANK_PARITY_EN is defined.
interface tff_bank_if #(
  parameter int WIDTH = 4
);
  logic             en_i;
  logic [2:0]       mode_i;
  logic [WIDTH-1:0] d_i;
  logic [WIDTH-1:0] t_i;
  logic [WIDTH-1:0] k_i;
  logic [WIDTH-1:0] q_o;
  logic [WIDTH-1:0] qn_o;
  logic             changed_o;
  logic             wrap_o;
`ifdef TFF_BANK_PARITY_EN
  logic             parity_o;
`endif

  modport master (
    output en_i, mode_i, d_i, t_i, k_i,
`ifdef TFF_BANK_PARITY_EN
    input  parity_o,
`endif
    input  q_o, qn_o, changed_o, wrap_o
  );

  modport slave (
    input  en_i, mode_i, d_i, t_i, k_i,
`ifdef TFF_BANK_PARITY_EN
    output parity_o,
`endif
    output q_o, qn_o, changed_o, wrap_o
  );
endinterface

// File: rtl/tff_bank.sv
// Multi-mode WIDTH-bit flip-flop bank: hold/load/toggle/JK/set/clear/count up/count down.
// Optional registered even parity of q when TFF_BANK_PARITY_EN is defined.
module tff_bank #(
  parameter int               WIDTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
  input  logic       clk_i,
  input  logic       rst_i,
  tff_bank_if.slave  bus
);

  localparam logic [2:0] MODE_HOLD = 3'd0;
  localparam logic [2:0] MODE_LOAD = 3'd1;
  localparam logic [2:0] MODE_TGL  = 3'd2;
  localparam logic [2:0] MODE_JK   = 3'd3;
  localparam logic [2:0] MODE_SET  = 3'd4;
  localparam logic [2:0] MODE_CLR  = 3'd5;
  localparam logic [2:0] MODE_CUP  = 3'd6;
  localparam logic [2:0] MODE_CDN  = 3'd7;

  localparam logic [WIDTH-1:0] ALL_ONES  = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ALL_ZEROS = {WIDTH{1'b0}};

  function automatic logic even_parity(input logic [WIDTH-1:0] v);
    return ^v;
  endfunction

  logic [WIDTH-1:0] q_q, q_d;
  logic             changed_q, changed_d;
  logic             wrap_q, wrap_d;
  logic [WIDTH-1:0] up_mask_s, dn_mask_s, jk_next_s;
  logic             up_run_s, dn_run_s;

  // Chained-T toggle masks: bit i toggles when all lower bits are 1 (up) or 0 (down)
  always_comb begin
    up_mask_s = {WIDTH{1'b0}};
    dn_mask_s = {WIDTH{1'b0}};
    up_run_s  = 1'b1;
    dn_run_s  = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      up_mask_s[i] = up_run_s;
      dn_mask_s[i] = dn_run_s;
      up_run_s     = up_run_s & q_q[i];
      dn_run_s     = dn_run_s & ~q_q[i];
    end
  end

  // Per-bit JK truth table with J taken from the t vector
  always_comb begin
    jk_next_s = q_q;
    for (int i = 0; i < WIDTH; i++) begin
      case ({bus.t_i[i], bus.k_i[i]})
        2'b10:   jk_next_s[i] = 1'b1;
        2'b01:   jk_next_s[i] = 1'b0;
        2'b11:   jk_next_s[i] = ~q_q[i];
        default: jk_next_s[i] = q_q[i];
      endcase
    end
  end

  // Next-state selection and one-shot flags
  always_comb begin
    q_d    = q_q;
    wrap_d = 1'b0;
    if (bus.en_i) begin
      case (bus.mode_i)
        MODE_HOLD: q_d = q_q;
        MODE_LOAD: q_d = bus.d_i;
        MODE_TGL:  q_d = q_q ^ bus.t_i;
        MODE_JK:   q_d = jk_next_s;
        MODE_SET:  q_d = q_q | bus.t_i;
        MODE_CLR:  q_d = q_q & ~bus.t_i;
        MODE_CUP: begin
          q_d    = q_q ^ up_mask_s;
          wrap_d = (q_q == ALL_ONES);
        end
        MODE_CDN: begin
          q_d    = q_q ^ dn_mask_s;
          wrap_d = (q_q == ALL_ZEROS);
        end
        default: q_d = q_q;
      endcase
    end else begin
      q_d    = q_q;
      wrap_d = 1'b0;
    end
    changed_d = bus.en_i && (q_d != q_q);
  end

  // State and flag registers, reset wins over enable and mode
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      q_q       <= RESET_VAL;
      changed_q <= 1'b0;
      wrap_q    <= 1'b0;
    end else begin
      q_q       <= q_d;
      changed_q <= changed_d;
      wrap_q    <= wrap_d;
    end
  end

`ifdef TFF_BANK_PARITY_EN
  logic parity_q;

  // Parity tracks the value written into q on the same edge
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      parity_q <= even_parity(RESET_VAL);
    end else begin
      parity_q <= even_parity(q_d);
    end
  end

  assign bus.parity_o = parity_q;
`endif

  assign bus.q_o       = q_q;
  assign bus.qn_o      = ~q_q;
  assign bus.changed_o = changed_q;
  assign bus.wrap_o    = wrap_q;

endmodule
